buzzer_arbiter: RTL and testbench
=================================

# buzzer_arbiter

Shares the single buzzer/PWM frequency path between three note sources: keyboard free play, learning-mode playback, and auto/memory playback. It sits between the note generators and the `Buzz` driver and presents one registered `frequency` word to it. Requesters are granted on a fixed-priority basis. A higher-priority requester can preempt the owner only at a note boundary. Every hand-over is separated by a forced silence gap so notes from different sources never run together.

## Interface
**Parameters**
- `FREQ_W`, 32: width of frequency words.
- `GAP_CYCLES`, 1_000_000: silence cycles inserted before every grant. Must be ≥1.
- `MAX_HOLD`, 500_000_000: owner cycles after which a waiting requester may take over. Must be ≥2.

**Ports**
- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, 3: per-source request, level. Bit 0 is keyboard (highest priority), bit 1 is learning, bit 2 is auto/memory (lowest).
- `freq0`, `freq1`, `freq2`, in, `FREQ_W` each: frequency presented by each source. A value of 0 means rest.
- `note_end`, in, 3: one-cycle pulse from a source marking the last cycle of its current note.
- `grant`, out, 3: one-hot owner; all zero when no source owns the buzzer.
- `start`, out, 3: one-cycle pulse on the first cycle of a new grant, same bit position as `grant`.
- `frequency`, out, `FREQ_W`: registered frequency to `Buzz`.
- `busy`, out, 1: high in the GAP or OWN state.
- `switch_count`, out, 8: number of grants issued; saturates at 255.

## Operation
**State machine**
- **IDLE**
  - Outputs: `grant`=0, `frequency`=0.
  - If any `req` bit is set: load `pending` with the lowest set index, load `gap_cnt`=`GAP_CYCLES`-1, go to GAP.
- **GAP**
  - Outputs: `grant`=0, `frequency`=0.
  - Each cycle, `gap_cnt` decrements by 1.
  - When `gap_cnt`==0 and `req[pending]`=1: go to OWN with `owner`=`pending`, `hold_cnt`=0, pulse `start[pending]`, and increment `switch_count` (saturating).
  - When `gap_cnt`==0 and `req[pending]`=0: go to IDLE.
  - New requests arriving during GAP do not change `pending`.
- **OWN**
  - Outputs: `grant`=onehot(`owner`); `frequency` is registered from `freq[owner]` every cycle.
  - `hold_cnt` increments and saturates at `MAX_HOLD`-1.
  - Exit conditions, highest precedence first:
    1. `req[owner]`=0: go to IDLE, and `frequency`=0 on the next cycle.
    2. `note_end[owner]`=1 and some `req` bit with a lower index than `owner` is set: go to GAP with `pending` = lowest such index (preemption).
    3. `note_end[owner]`=1 and `hold_cnt`==`MAX_HOLD`-1 and some other `req` bit is set: go to GAP with `pending` = lowest set index other than `owner` (fairness; priority ignored).
  - Otherwise stay in OWN. `note_end` from non-owners is ignored.

**Rules**
- Grant and frequency are never changed mid-note. The only exception is the owner dropping `req`, which silences immediately.
- After a fairness hand-over, the previous owner re-competes normally when it next requests.
- When the owner drops `req` while others are waiting, the block spends one cycle in IDLE before entering GAP.

## Timing
- **Reset:** `reset`=0 immediately forces IDLE, `grant`=0, `start`=0, `frequency`=0, `busy`=0, `switch_count`=0, and all counters to 0. Reset asserted mid-note silences the buzzer asynchronously.
- **Grant latency:** if `req` rises while in IDLE at cycle N, the block is in GAP for cycles N+1 … N+`GAP_CYCLES`. `grant`, `start` and `frequency` become valid at cycle N+`GAP_CYCLES`+1. `frequency` at that cycle equals `freq[pending]` sampled at the transition edge.
- **Frequency tracking:** `frequency` follows `freq[owner]` with 1 cycle of latency.
- **Preemption latency:** `note_end` at cycle M leads to GAP from M+1, and the new grant arrives at M+`GAP_CYCLES`+1.
- **Simultaneous events:**
  - Owner drop together with `note_end`: the drop wins.
  - Preemption and fairness in the same cycle: preemption wins.
  - Multiple requests rising in the same cycle: the lowest index wins.
- **Saturation:** `switch_count` stays at 255 once reached; `hold_cnt` never wraps.

## Test plan
Bench parameters: `GAP_CYCLES`=4, `MAX_HOLD`=16.
1. **Reset and single grant:** after reset, raise `req`=3'b100 with `freq2`=523 at cycle 10. Expect `busy` at cycle 11, `grant`=3'b100, `start`=3'b100 and `frequency`=523 at cycle 15, and `switch_count`=1.
2. **Preemption at note boundary:** with source 2 owning, raise `req[0]` at cycle 20 and pulse `note_end[2]` at cycle 30. Expect `grant` to stay at 3'b100 through cycle 30, `frequency`=0 for cycles 31–34, and `grant`=3'b001 at cycle 35.
3. **No preemption without note_end, and lower priority never preempts:** with source 1 owning, raise `req[2]` and never pulse `note_end`. Expect `grant` to stay at 3'b010 indefinitely.
4. **Fairness timeout:** with source 0 owning and `req[1]` waiting, pulse `note_end[0]` at `hold_cnt`=15. Expect a 4-cycle gap, then `grant`=3'b010. A `note_end[0]` pulse at `hold_cnt`<15 must not cause a hand-over.
5. **Owner drop and gap abort:**
   - Drop the owner's `req`: expect `frequency`=0 and `grant`=0 on the next cycle.
   - Drop `req[pending]` during GAP: expect a return to IDLE, no `start` pulse, and `switch_count` unchanged.
6. **Asynchronous reset mid-note and counter saturation:** assert `reset` low between clock edges while `frequency`=659. Expect all outputs at 0 before the next edge. Then force 300 grants and expect `switch_count`=255.

Source files
------------

// File: rtl/buzzer_arbiter.sv
// Purpose: fixed-priority owner selection for the shared buzzer frequency path, silence gap on every hand-over.
// Latency: grant/frequency valid GAP_CYCLES+1 cycles after a request from IDLE; frequency tracks owner with 1 cycle.
// Backpressure: none; requests are levels, hand-over happens only at a note boundary or on owner drop.
module buzzer_arbiter #(
  parameter int FREQ_W     = 32,
  parameter int GAP_CYCLES = 1_000_000,
  parameter int MAX_HOLD   = 500_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        req,
  input  logic [FREQ_W-1:0] freq0,
  input  logic [FREQ_W-1:0] freq1,
  input  logic [FREQ_W-1:0] freq2,
  input  logic [2:0]        note_end,
  output logic [2:0]        grant,
  output logic [2:0]        start,
  output logic [FREQ_W-1:0] frequency,
  output logic              busy,
  output logic [7:0]        switch_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_OWN  = 2'd2;

  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int HOLD_W = $clog2(MAX_HOLD);
  localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  logic [1:0]        state;
  logic [1:0]        pending;
  logic [1:0]        owner;
  logic [GAP_W-1:0]  gap_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  logic              own_req;
  logic              own_end;
  logic              pend_req;
  logic [FREQ_W-1:0] own_freq;
  logic [FREQ_W-1:0] pend_freq;
  logic [2:0]        lower_mask;
  logic [2:0]        preempt_req;
  logic [2:0]        fair_req;

  // Index 0 is the highest-priority source, so the lowest set bit wins.
  function automatic logic [1:0] lowest_idx(input logic [2:0] v);
    if (v[0])      lowest_idx = 2'd0;
    else if (v[1]) lowest_idx = 2'd1;
    else           lowest_idx = 2'd2;
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] idx);
    onehot = 3'b001 << idx;
  endfunction

  assign busy = (state == S_GAP) || (state == S_OWN);

  // Per-index views of the owner and pending source, plus the masks that decide hand-over targets.
  always_comb begin
    own_req    = 1'b0;
    own_end    = 1'b0;
    own_freq   = '0;
    lower_mask = 3'b000;
    case (owner)
      2'd0: begin own_req = req[0]; own_end = note_end[0]; own_freq = freq0; lower_mask = 3'b000; end
      2'd1: begin own_req = req[1]; own_end = note_end[1]; own_freq = freq1; lower_mask = 3'b001; end
      2'd2: begin own_req = req[2]; own_end = note_end[2]; own_freq = freq2; lower_mask = 3'b011; end
      default: ;
    endcase
    pend_req  = 1'b0;
    pend_freq = '0;
    case (pending)
      2'd0: begin pend_req = req[0]; pend_freq = freq0; end
      2'd1: begin pend_req = req[1]; pend_freq = freq1; end
      2'd2: begin pend_req = req[2]; pend_freq = freq2; end
      default: ;
    endcase
    preempt_req = req & lower_mask;
    fair_req    = req & ~onehot(owner);
  end

  // Arbitration FSM; grant/start/frequency are all registered so the buzzer never sees a combinational glitch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      pending      <= 2'd0;
      owner        <= 2'd0;
      gap_cnt      <= '0;
      hold_cnt     <= '0;
      grant        <= 3'b000;
      start        <= 3'b000;
      frequency    <= '0;
      switch_count <= 8'd0;
    end else begin
      start <= 3'b000;
      case (state)
        S_IDLE: begin
          grant     <= 3'b000;
          frequency <= '0;
          if (|req) begin
            pending <= lowest_idx(req);
            gap_cnt <= GAP_LOAD;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          grant     <= 3'b000;
          frequency <= '0;
          if (gap_cnt == '0) begin
            // Pending is frozen for the whole gap; if it gave up meanwhile, start over from IDLE.
            if (pend_req) begin
              state     <= S_OWN;
              owner     <= pending;
              hold_cnt  <= '0;
              grant     <= onehot(pending);
              start     <= onehot(pending);
              frequency <= pend_freq;
              if (switch_count != 8'hFF) switch_count <= switch_count + 8'd1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        S_OWN: begin
          if (!own_req) begin
            // Owner releasing silences at once, even mid-note.
            state     <= S_IDLE;
            grant     <= 3'b000;
            frequency <= '0;
          end else if (own_end && (|preempt_req)) begin
            state     <= S_GAP;
            pending   <= lowest_idx(preempt_req);
            gap_cnt   <= GAP_LOAD;
            grant     <= 3'b000;
            frequency <= '0;
          end else if (own_end && (hold_cnt == HOLD_MAX) && (|fair_req)) begin
            // Long-held owner yields to anyone waiting, regardless of priority.
            state     <= S_GAP;
            pending   <= lowest_idx(fair_req);
            gap_cnt   <= GAP_LOAD;
            grant     <= 3'b000;
            frequency <= '0;
          end else begin
            frequency <= own_freq;
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          grant     <= 3'b000;
          frequency <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Purpose: directed self-checking bench for buzzer_arbiter with GAP_CYCLES=4, MAX_HOLD=16.
// Latency: cycle N is the interval after the N-th rising edge; inputs change and outputs are sampled 1 time unit after it.
// Backpressure: not applicable.
module tb_buzzer_arbiter;

  localparam int FREQ_W = 32;

  logic              clk;
  logic              reset;
  logic [2:0]        req;
  logic [FREQ_W-1:0] freq0;
  logic [FREQ_W-1:0] freq1;
  logic [FREQ_W-1:0] freq2;
  logic [2:0]        note_end;
  logic [2:0]        grant;
  logic [2:0]        start;
  logic [FREQ_W-1:0] frequency;
  logic              busy;
  logic [7:0]        switch_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  buzzer_arbiter #(
    .FREQ_W(FREQ_W),
    .GAP_CYCLES(4),
    .MAX_HOLD(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .freq0(freq0),
    .freq1(freq1),
    .freq2(freq2),
    .note_end(note_end),
    .grant(grant),
    .start(start),
    .frequency(frequency),
    .busy(busy),
    .switch_count(switch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, {29'd0, grant}, 32'd0);
    chk({tag, "_start"}, {29'd0, start}, 32'd0);
    chk({tag, "_freq"}, frequency, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_count"}, {24'd0, switch_count}, 32'd0);
  endtask

  initial begin
    reset    = 1'b0;
    req      = 3'b000;
    note_end = 3'b000;
    freq0    = 262;
    freq1    = 330;
    freq2    = 523;

    // Reset state
    tick();
    chk_all_zero("reset");
    tick();
    reset = 1'b1;

    // 1: single grant from IDLE
    goto(10);
    req = 3'b100;
    tick();
    chk("t1_busy11", {31'd0, busy}, 32'd1);
    chk("t1_grant11", {29'd0, grant}, 32'd0);
    goto(14);
    chk("t1_grant14", {29'd0, grant}, 32'd0);
    chk("t1_freq14", frequency, 32'd0);
    tick();
    chk("t1_grant15", {29'd0, grant}, 32'b100);
    chk("t1_start15", {29'd0, start}, 32'b100);
    chk("t1_freq15", frequency, 32'd523);
    chk("t1_count15", {24'd0, switch_count}, 32'd1);
    tick();
    chk("t1_start16", {29'd0, start}, 32'd0);

    // 2: preemption only at a note boundary
    goto(20);
    req = 3'b101;
    while (cyc < 30) begin
      tick();
      chk("t2_hold_grant", {29'd0, grant}, 32'b100);
    end
    note_end = 3'b100;
    tick();
    note_end = 3'b000;
    while (cyc < 35) begin
      chk("t2_gap_freq", frequency, 32'd0);
      chk("t2_gap_grant", {29'd0, grant}, 32'd0);
      tick();
    end
    chk("t2_grant35", {29'd0, grant}, 32'b001);
    chk("t2_start35", {29'd0, start}, 32'b001);
    chk("t2_freq35", frequency, 32'd262);
    chk("t2_count35", {24'd0, switch_count}, 32'd2);

    // 5a: owner drop silences next cycle, one IDLE cycle before the next gap
    req = 3'b010;
    tick();
    chk("t5_drop_grant", {29'd0, grant}, 32'd0);
    chk("t5_drop_freq", frequency, 32'd0);
    chk("t5_drop_busy", {31'd0, busy}, 32'd0);
    goto(40);
    chk("t5_gap40_grant", {29'd0, grant}, 32'd0);
    tick();
    chk("t3_grant41", {29'd0, grant}, 32'b010);
    chk("t3_start41", {29'd0, start}, 32'b010);
    chk("t3_freq41", frequency, 32'd330);
    chk("t3_count41", {24'd0, switch_count}, 32'd3);

    // 3: lower priority never preempts; non-owner note_end ignored; frequency tracking
    req = 3'b110;
    while (cyc < 61) begin
      tick();
      chk("t3_keep_grant", {29'd0, grant}, 32'b010);
      if (cyc == 45) freq1 = 349;
      if (cyc == 46) chk("t3_track_freq", frequency, 32'd349);
      if (cyc == 50) note_end = 3'b100;
      if (cyc == 51) note_end = 3'b000;
    end

    // Preempt source 1 in favour of source 0
    req      = 3'b011;
    note_end = 3'b010;
    tick();
    note_end = 3'b000;
    chk("t4_pre_gap_grant", {29'd0, grant}, 32'd0);
    chk("t4_pre_gap_busy", {31'd0, busy}, 32'd1);
    goto(66);
    chk("t4_grant66", {29'd0, grant}, 32'b001);
    chk("t4_count66", {24'd0, switch_count}, 32'd4);

    // 4: early note_end (hold_cnt=5) does not hand over
    goto(71);
    note_end = 3'b001;
    tick();
    note_end = 3'b000;
    chk("t4_early_grant", {29'd0, grant}, 32'b001);

    // 4: note_end at hold_cnt=15 hands over to waiting source 1
    goto(81);
    chk("t4_grant81", {29'd0, grant}, 32'b001);
    note_end = 3'b001;
    tick();
    note_end = 3'b000;
    chk("t4_gap82_grant", {29'd0, grant}, 32'd0);
    chk("t4_gap82_freq", frequency, 32'd0);
    goto(85);
    chk("t4_gap85_grant", {29'd0, grant}, 32'd0);
    tick();
    chk("t4_grant86", {29'd0, grant}, 32'b010);
    chk("t4_start86", {29'd0, start}, 32'b010);
    chk("t4_freq86", frequency, 32'd349);
    chk("t4_count86", {24'd0, switch_count}, 32'd5);

    // 5b: pending source withdraws during the gap
    req = 3'b100;
    tick();
    chk("t5b_idle_busy", {31'd0, busy}, 32'd0);
    tick();
    chk("t5b_gap_busy", {31'd0, busy}, 32'd1);
    tick();
    req = 3'b000;
    goto(91);
    chk("t5b_gap91_start", {29'd0, start}, 32'd0);
    tick();
    chk("t5b_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5b_abort_grant", {29'd0, grant}, 32'd0);
    chk("t5b_abort_start", {29'd0, start}, 32'd0);
    chk("t5b_abort_count", {24'd0, switch_count}, 32'd5);

    // 6: asynchronous reset mid-note
    freq0 = 659;
    req   = 3'b001;
    goto(97);
    chk("t6_grant97", {29'd0, grant}, 32'b001);
    chk("t6_freq97", frequency, 32'd659);
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    req = 3'b000;
    tick();
    chk_all_zero("t6_held");
    reset = 1'b1;

    // 6: switch_count saturation over 300 grants
    for (int i = 1; i <= 300; i++) begin
      req = 3'b001;
      repeat (5) tick();
      if (i == 1)   chk("t6_count1", {24'd0, switch_count}, 32'd1);
      if (i == 254) chk("t6_count254", {24'd0, switch_count}, 32'd254);
      if (i == 255) chk("t6_count255", {24'd0, switch_count}, 32'd255);
      req = 3'b000;
      tick();
    end
    chk("t6_count300", {24'd0, switch_count}, 32'd255);
    chk("t6_end_busy", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
